// File: rtl/alu_op_sequencer.sv
// Issue/retire stage around a 4-bit combinational ALU: command FIFO, registered ALU operands, masked result capture.
// Optional macro ACC_FWD_EN adds i_in_use_acc to source operand A from the last captured result.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_in_a,
    input  logic [3:0]       i_in_b,
    input  logic [1:0]       i_in_op,
`ifdef ACC_FWD_EN
    input  logic             i_in_use_acc,
`endif
    output logic [3:0]       o_alu_a,
    output logic [3:0]       o_alu_b,
    output logic [1:0]       o_alu_s,
    input  logic [3:0]       i_alu_final,
    input  logic             i_alu_carry,
    input  logic             i_alu_eq,
    input  logic             i_alu_a_gt_b,
    input  logic             i_alu_b_gt_a,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [3:0]       o_out_result,
    output logic             o_out_carry,
    output logic             o_out_eq,
    output logic             o_out_a_gt_b,
    output logic             o_out_b_gt_a,
    output logic [1:0]       o_out_op,
    output logic [PTR_W:0]   o_fifo_count
);

    // state | meaning
    // IDLE  | no command in flight, waiting for FIFO data
    // EXEC  | ALU operands registered, ALU settling for a full cycle
    // HOLD  | result presented, waiting for downstream acceptance
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [3:0]        r_mem_a  [DEPTH];
    logic [3:0]        r_mem_b  [DEPTH];
    logic [1:0]        r_mem_op [DEPTH];
`ifdef ACC_FWD_EN
    logic              r_mem_acc [DEPTH];
`endif
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic [3:0]        r_alu_a;
    logic [3:0]        r_alu_b;
    logic [1:0]        r_alu_s;

    logic              r_out_valid;
    logic [3:0]        r_out_result;
    logic              r_out_carry;
    logic              r_out_eq;
    logic              r_out_a_gt_b;
    logic              r_out_b_gt_a;
    logic [1:0]        r_out_op;

    logic              w_push;
    logic              w_pop;
    logic              w_capture;
    logic              w_retire;
    logic              w_not_empty;
    logic [3:0]        w_head_a;

    logic [3:0]        w_res;
    logic              w_car;
    logic              w_eq;
    logic              w_agb;
    logic              w_bga;

    // Ready depends only on the registered count, so a pop never opens a full FIFO in the same cycle.
    assign o_in_ready  = (r_count != L_FULL);
    assign w_push      = i_in_valid & o_in_ready;
    assign w_not_empty = (r_count != '0);

`ifdef ACC_FWD_EN
    assign w_head_a = r_mem_acc[r_rd_ptr] ? r_out_result : r_mem_a[r_rd_ptr];
`else
    assign w_head_a = r_mem_a[r_rd_ptr];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_out_ready) begin
                    w_retire = 1'b1;
                    if (w_not_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Only the outputs meaningful for the issued op are passed through.
    always_comb begin
        w_res = 4'h0;
        w_car = 1'b0;
        w_eq  = 1'b0;
        w_agb = 1'b0;
        w_bga = 1'b0;
        case (r_alu_s)
            2'b00, 2'b01: begin
                w_res = i_alu_final;
                w_car = i_alu_carry;
            end
            2'b10: begin
                w_eq  = i_alu_eq;
                w_agb = i_alu_a_gt_b;
                w_bga = i_alu_b_gt_a;
            end
            2'b11: w_res = i_alu_final;
            default: w_res = 4'h0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= i_in_a;
            r_mem_b[r_wr_ptr]  <= i_in_b;
            r_mem_op[r_wr_ptr] <= i_in_op;
`ifdef ACC_FWD_EN
            r_mem_acc[r_wr_ptr] <= i_in_use_acc;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_alu_a      <= 4'h0;
            r_alu_b      <= 4'h0;
            r_alu_s      <= 2'b00;
            r_out_valid  <= 1'b0;
            r_out_result <= 4'h0;
            r_out_carry  <= 1'b0;
            r_out_eq     <= 1'b0;
            r_out_a_gt_b <= 1'b0;
            r_out_b_gt_a <= 1'b0;
            r_out_op     <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_alu_a  <= w_head_a;
                r_alu_b  <= r_mem_b[r_rd_ptr];
                r_alu_s  <= r_mem_op[r_rd_ptr];
            end
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
            if (w_capture) begin
                r_out_valid  <= 1'b1;
                r_out_result <= w_res;
                r_out_carry  <= w_car;
                r_out_eq     <= w_eq;
                r_out_a_gt_b <= w_agb;
                r_out_b_gt_a <= w_bga;
                r_out_op     <= r_alu_s;
            end else if (w_retire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_s      = r_alu_s;
    assign o_out_valid  = r_out_valid;
    assign o_out_result = r_out_result;
    assign o_out_carry  = r_out_carry;
    assign o_out_eq     = r_out_eq;
    assign o_out_a_gt_b = r_out_a_gt_b;
    assign o_out_b_gt_a = r_out_b_gt_a;
    assign o_out_op     = r_out_op;
    assign o_fifo_count = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: table of ALU commands with hand-computed results plus
// backpressure, full-FIFO, push/pop, reset and (with ACC_FWD_EN) accumulator sequences.
module tb_alu_op_sequencer;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       c;
        logic       eq;
        logic       agb;
        logic       bga;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic       in_use_acc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_s;
    logic [3:0] alu_final;
    logic       alu_carry;
    logic       alu_eq;
    logic       alu_a_gt_b;
    logic       alu_b_gt_a;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic       out_eq;
    logic       out_a_gt_b;
    logic       out_b_gt_a;
    logic [1:0] out_op;
    logic [2:0] fifo_count;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs [12];
    vec_t bp   [5];
    vec_t sp   [3];
    vec_t rv   [3];

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_a       (in_a),
        .i_in_b       (in_b),
        .i_in_op      (in_op),
`ifdef ACC_FWD_EN
        .i_in_use_acc (in_use_acc),
`endif
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_s      (alu_s),
        .i_alu_final  (alu_final),
        .i_alu_carry  (alu_carry),
        .i_alu_eq     (alu_eq),
        .i_alu_a_gt_b (alu_a_gt_b),
        .i_alu_b_gt_a (alu_b_gt_a),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_result (out_result),
        .o_out_carry  (out_carry),
        .o_out_eq     (out_eq),
        .o_out_a_gt_b (out_a_gt_b),
        .o_out_b_gt_a (out_b_gt_a),
        .o_out_op     (out_op),
        .o_fifo_count (fifo_count)
    );

    // External ALU; fields that the op does not own carry junk so masking is exercised.
    logic [4:0] sum5;
    always_comb begin
        sum5       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_final  = 4'h0;
        alu_carry  = 1'b0;
        case (alu_s)
            2'b00: begin alu_final = sum5[3:0];     alu_carry = sum5[4];         end
            2'b01: begin alu_final = alu_a - alu_b; alu_carry = (alu_a >= alu_b); end
            2'b10: begin alu_final = alu_a ^ alu_b; alu_carry = 1'b1;            end
            default: begin alu_final = alu_a & alu_b; alu_carry = 1'b1;          end
        endcase
        alu_eq     = (alu_a == alu_b);
        alu_a_gt_b = (alu_a > alu_b);
        alu_b_gt_a = (alu_b > alu_a);
    end

    function automatic vec_t mk(logic [1:0] op, logic [3:0] a, logic [3:0] b, logic [3:0] res,
                                logic c, logic eq, logic agb, logic bga);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res;
        v.c = c; v.eq = eq; v.agb = agb; v.bga = bga;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v, input string name);
        chk({name, ".valid"},  {7'd0, out_valid}, 8'd1);
        chk({name, ".result"}, {4'd0, out_result}, {4'd0, v.res});
        chk({name, ".carry"},  {7'd0, out_carry},  {7'd0, v.c});
        chk({name, ".eq"},     {7'd0, out_eq},     {7'd0, v.eq});
        chk({name, ".a_gt_b"}, {7'd0, out_a_gt_b}, {7'd0, v.agb});
        chk({name, ".b_gt_a"}, {7'd0, out_b_gt_a}, {7'd0, v.bga});
        chk({name, ".op"},     {6'd0, out_op},     {6'd0, v.op});
    endtask

    task automatic push(input vec_t v, input logic acc);
        int k = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_a       = v.a;
        in_b       = v.b;
        in_op      = v.op;
        in_use_acc = acc;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: in_ready 0 expected 1");
        end
        @(negedge clk);
        in_valid   = 1'b0;
        in_use_acc = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.timeout: out_valid 0 expected 1", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        vecs[0]  = mk(2'b00, 4'h9, 4'h8, 4'h1, 1, 0, 0, 0);
        vecs[1]  = mk(2'b01, 4'h3, 4'h5, 4'hE, 0, 0, 0, 0);
        vecs[2]  = mk(2'b10, 4'h7, 4'h7, 4'h0, 0, 1, 0, 0);
        vecs[3]  = mk(2'b11, 4'hC, 4'hA, 4'h8, 0, 0, 0, 0);
        vecs[4]  = mk(2'b00, 4'hF, 4'h1, 4'h0, 1, 0, 0, 0);
        vecs[5]  = mk(2'b01, 4'h5, 4'h5, 4'h0, 1, 0, 0, 0);
        vecs[6]  = mk(2'b10, 4'h2, 4'h9, 4'h0, 0, 0, 0, 1);
        vecs[7]  = mk(2'b10, 4'hA, 4'h3, 4'h0, 0, 0, 1, 0);
        vecs[8]  = mk(2'b00, 4'h3, 4'h4, 4'h7, 0, 0, 0, 0);
        vecs[9]  = mk(2'b01, 4'h0, 4'h1, 4'hF, 0, 0, 0, 0);
        vecs[10] = mk(2'b11, 4'hF, 4'hF, 4'hF, 0, 0, 0, 0);
        vecs[11] = mk(2'b01, 4'h9, 4'h2, 4'h7, 1, 0, 0, 0);

        bp[0] = mk(2'b00, 4'h1, 4'h1, 4'h2, 0, 0, 0, 0);
        bp[1] = mk(2'b01, 4'h8, 4'h3, 4'h5, 1, 0, 0, 0);
        bp[2] = mk(2'b11, 4'h6, 4'h3, 4'h2, 0, 0, 0, 0);
        bp[3] = mk(2'b00, 4'h7, 4'h9, 4'h0, 1, 0, 0, 0);
        bp[4] = mk(2'b10, 4'h1, 4'h2, 4'h0, 0, 0, 0, 1);

        sp[0] = mk(2'b00, 4'h2, 4'h2, 4'h4, 0, 0, 0, 0);
        sp[1] = mk(2'b01, 4'hF, 4'h1, 4'hE, 1, 0, 0, 0);
        sp[2] = mk(2'b11, 4'hC, 4'hA, 4'h8, 0, 0, 0, 0);

        rv[0] = mk(2'b00, 4'h1, 4'h2, 4'h3, 0, 0, 0, 0);
        rv[1] = mk(2'b00, 4'h3, 4'h4, 4'h7, 0, 0, 0, 0);
        rv[2] = mk(2'b00, 4'h5, 4'h6, 4'hB, 0, 0, 0, 0);

        rst = 1'b1; in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0; in_op = 2'b00;
        in_use_acc = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst.in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst.count", {5'd0, fifo_count}, 8'd0);
        chk("rst.alu", {alu_a, alu_b[1:0], alu_s}, 8'd0);
        chk("rst.out_result", {4'd0, out_result}, 8'd0);
        rst = 1'b0;

        // Latency: accept at edge t, operands after t+1, result after t+2.
        out_ready = 1'b1;
        push(vecs[0], 1'b0);
        chk("lat.t0_valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        chk("lat.t1_valid", {7'd0, out_valid}, 8'd0);
        chk("lat.t1_alu", {alu_a, alu_b}, 8'h98);
        chk("lat.t1_sel", {6'd0, alu_s}, 8'd0);
        @(negedge clk);
        check_vec(vecs[0], "vec0");

        for (int i = 1; i < 12; i++) begin
            push(vecs[i], 1'b0);
            wait_valid($sformatf("vec%0d", i));
            check_vec(vecs[i], $sformatf("vec%0d", i));
        end
        @(negedge clk);
        chk("drain.valid", {7'd0, out_valid}, 8'd0);

        // Backpressure: one in flight plus four queued fills the FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(bp[i], 1'b0);
        chk("bp.count_full", {5'd0, fifo_count}, 8'd4);
        chk("bp.in_ready_full", {7'd0, in_ready}, 8'd0);
        check_vec(bp[0], "bp0_hold");
        repeat (3) @(negedge clk);
        chk("bp.stable_result", {4'd0, out_result}, {4'd0, bp[0].res});
        chk("bp.stable_valid", {7'd0, out_valid}, 8'd1);
        out_ready = 1'b1;
        chk("bp.no_bypass", {7'd0, in_ready}, 8'd0);
        @(negedge clk);
        chk("bp.count_after_pop", {5'd0, fifo_count}, 8'd3);
        chk("bp.in_ready_after_pop", {7'd0, in_ready}, 8'd1);
        for (int i = 1; i < 5; i++) begin
            wait_valid($sformatf("bp%0d", i));
            check_vec(bp[i], $sformatf("bp%0d", i));
            @(negedge clk);
        end

        // Push and pop on the same edge leave the count unchanged.
        out_ready = 1'b0;
        push(sp[0], 1'b0);
        push(sp[1], 1'b0);
        chk("sp.count_before", {5'd0, fifo_count}, 8'd1);
        check_vec(sp[0], "sp0");
        in_valid = 1'b1; in_a = sp[2].a; in_b = sp[2].b; in_op = sp[2].op;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("sp.count_same", {5'd0, fifo_count}, 8'd1);
        chk("sp.valid_drop", {7'd0, out_valid}, 8'd0);
        wait_valid("sp1");
        check_vec(sp[1], "sp1");
        @(negedge clk);
        wait_valid("sp2");
        check_vec(sp[2], "sp2");
        @(negedge clk);

        // Reset while holding a result with two queued discards everything.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(rv[i], 1'b0);
        chk("rr.count_before", {5'd0, fifo_count}, 8'd2);
        chk("rr.valid_before", {7'd0, out_valid}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr.valid", {7'd0, out_valid}, 8'd0);
        chk("rr.count", {5'd0, fifo_count}, 8'd0);
        chk("rr.in_ready", {7'd0, in_ready}, 8'd1);
        chk("rr.out_result", {4'd0, out_result}, 8'd0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rr.no_stale", {7'd0, seen}, 8'd0);
        push(vecs[11], 1'b0);
        wait_valid("rr_post");
        check_vec(vecs[11], "rr_post");
        @(negedge clk);

`ifdef ACC_FWD_EN
        push(mk(2'b00, 4'h2, 4'h3, 4'h5, 0, 0, 0, 0), 1'b0);
        wait_valid("acc0");
        check_vec(mk(2'b00, 4'h2, 4'h3, 4'h5, 0, 0, 0, 0), "acc0");
        push(mk(2'b00, 4'hF, 4'h4, 4'h9, 0, 0, 0, 0), 1'b1);
        wait_valid("acc1");
        check_vec(mk(2'b00, 4'hF, 4'h4, 4'h9, 0, 0, 0, 0), "acc1");
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue/retire stage wrapped around the 4-bit combinational ALU (add, sub, compare, AND).
- Accepts operation commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives registered, stable A/B/S operands into the ALU, then captures its outputs into a result register.
- Masks outputs that do not belong to the issued op, and presents results downstream over a valid/ready handshake.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- PTR_W, 2, FIFO pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept.
- in_a  input  4  operand A.
- in_b  input  4  operand B.
- in_op  input  2  op code: 00 add, 01 sub, 10 compare, 11 AND.
- alu_a  output  4  registered operand A to the ALU.
- alu_b  output  4  registered operand B to the ALU.
- alu_s  output  2  registered select to the ALU.
- alu_final  input  4  ALU result.
- alu_carry  input  1  ALU carry.
- alu_eq  input  1  ALU equality flag.
- alu_a_gt_b  input  1  ALU A>B flag.
- alu_b_gt_a  input  1  ALU B>A flag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- out_result  output  4  captured result.
- out_carry  output  1  captured carry.
- out_eq  output  1  captured equality flag.
- out_a_gt_b  output  1  captured A>B flag.
- out_b_gt_a  output  1  captured B>A flag.
- out_op  output  2  op code of the result.
- fifo_count  output  PTR_W+1  occupied FIFO entries.

Behaviour:
- Reset: state IDLE; fifo_count, pointers, alu_a, alu_b, alu_s, all out_* = 0; out_valid = 0. Reset mid-operation discards queued and in-flight commands with no output.
- in_ready = (fifo_count != DEPTH), from registered count only. A push occurs on in_valid & in_ready.
- Full FIFO: a same-cycle pop does not open in_ready that cycle.
- FSM IDLE:
  - FIFO non-empty: pop head into alu_a, alu_b, alu_s; go EXEC.
  - Otherwise stay in IDLE.
- FSM EXEC (ALU inputs stable a full cycle): capture ALU outputs into out_* with masking, set out_valid = 1, out_op = alu_s; go HOLD.
- FSM HOLD:
  - out_valid stays high and out_* stay stable until out_ready.
  - On out_valid & out_ready with FIFO non-empty: pop next command, go EXEC, out_valid = 0.
  - On out_valid & out_ready with FIFO empty: go IDLE, out_valid = 0.
- Masking:
  - add/sub: result and carry from the ALU; eq, a_gt_b, b_gt_a = 0.
  - compare: flags from the ALU; result = 0, carry = 0.
  - AND: result from the ALU; carry and all flags = 0.
- Expected arithmetic (4-bit wrap):
  - add: result = (A+B) mod 16, carry = bit 4 of the sum.
  - sub: result = (A-B) mod 16, carry = 1 iff A >= B.
- Latency: a command accepted at edge t gives out_valid high after edge t+2 when the FIFO was empty and the FSM was in IDLE. With out_ready held high, throughput is one result per 2 cycles.
- Simultaneous push and pop: fifo_count unchanged; pointers each advance and wrap modulo DEPTH.
- Ordering: results appear strictly in command order; no drops, no duplicates.

Optional Feature:
- Macro ACC_FWD_EN.
- When defined:
  - Extra input port in_use_acc (1 bit), stored per FIFO entry.
  - At pop, if the stored bit is 1, alu_a is loaded from the last captured out_result instead of the stored A. The register holding that value is 0 after reset.
- When undefined: port absent; alu_a always comes from the stored A.

Test Plan:
- Reset, then push add A=4'h9, B=4'h8, out_ready=1 -> out_valid 2 cycles after accept; out_result=4'h1, out_carry=1, flags=0, out_op=00.
- Push sub A=3, B=5 -> out_result=4'hE, out_carry=0. Push compare A=7, B=7 -> out_eq=1, out_a_gt_b=0, out_b_gt_a=0, out_result=0.
- out_ready=0, push 5 commands with DEPTH=4 -> first result held stable in HOLD; then release out_ready -> all 5 retire in order.
  - in_ready=0 once fifo_count=4 (4 queued, 1 in flight).
- Push AND A=4'hC, B=4'hA while a pop occurs the same cycle -> fifo_count unchanged; out_result=4'h8, carry and flags 0.
- Assert rst while in HOLD with 2 queued -> next cycle: out_valid=0, fifo_count=0, in_ready=1; no stale results afterward.
- With ACC_FWD_EN: add 2+3, then add (use_acc=1, B=4) -> out_result=5 then 9.
